dct8_transpose_buf: RTL and testbench

Sits between the row-pass 8-point DCT and the column-pass 8-point DCT of the 2-D 8x8 forward transform. Each cycle it takes one row of 8 row-DCT coefficients and applies the HEVC first-stage rounding shift and saturation. It stores the results in a ping-pong pair of 8x8 banks and emits each completed block column by column, one column per cycle. Valid/ready handshakes on both sides give continuous one-row-per-cycle streaming and absorb backpressure from the column pass.

---
 rtl/dct8_transpose_buf.sv | 134 +++++++++++++
 tb/tb_dct8_transpose_buf.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct8_transpose_buf.sv
// Row-to-column transpose between the two 8-point DCT passes: scales/saturates each row, ping-pong 8x8 banks, emits columns.
// Column 0 valid one cycle after row 7 is accepted; in_ready depends only on bank state, output register holds under out_ready=0.
module dct8_transpose_buf #(
    parameter int WIDTH_X = 19,
    parameter int WIDTH_Y = 16,
    parameter int SHIFT   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH_X-1:0] x0,
    input  logic signed [WIDTH_X-1:0] x1,
    input  logic signed [WIDTH_X-1:0] x2,
    input  logic signed [WIDTH_X-1:0] x3,
    input  logic signed [WIDTH_X-1:0] x4,
    input  logic signed [WIDTH_X-1:0] x5,
    input  logic signed [WIDTH_X-1:0] x6,
    input  logic signed [WIDTH_X-1:0] x7,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [WIDTH_Y-1:0] y0,
    output logic signed [WIDTH_Y-1:0] y1,
    output logic signed [WIDTH_Y-1:0] y2,
    output logic signed [WIDTH_Y-1:0] y3,
    output logic signed [WIDTH_Y-1:0] y4,
    output logic signed [WIDTH_Y-1:0] y5,
    output logic signed [WIDTH_Y-1:0] y6,
    output logic signed [WIDTH_Y-1:0] y7,
    output logic [2:0]                out_col,
    output logic                      out_last
);

    // One extra bit so adding the rounding constant can never overflow.
    localparam int WE = WIDTH_X + 1;
    localparam logic signed [WE-1:0] RND  = WE'((2 ** SHIFT) / 2);
    localparam logic signed [WE-1:0] YMAX = WE'((2 ** (WIDTH_Y - 1)) - 1);
    localparam logic signed [WE-1:0] YMIN = ~YMAX;

    function automatic logic signed [WIDTH_Y-1:0] scale(input logic signed [WIDTH_X-1:0] x);
        logic signed [WE-1:0] e;
        logic signed [WE-1:0] r;
        e = {x[WIDTH_X-1], x};
        if (SHIFT == 0) r = e;
        else            r = (e + RND) >>> SHIFT;
        if (r > YMAX)      r = YMAX;
        else if (r < YMIN) r = YMIN;
        return WIDTH_Y'(r);
    endfunction

    logic signed [WIDTH_X-1:0] xa [8];
    logic signed [WIDTH_Y-1:0] sc [8];
    logic signed [WIDTH_Y-1:0] yr [8];
    logic signed [WIDTH_Y-1:0] mem [2][8][8];

    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_bank;
    logic       rd_bank;
    logic [2:0] wr_row;
    logic [2:0] rd_col;
    logic       wr_en;
    logic       ld;

    assign xa[0] = x0;
    assign xa[1] = x1;
    assign xa[2] = x2;
    assign xa[3] = x3;
    assign xa[4] = x4;
    assign xa[5] = x5;
    assign xa[6] = x6;
    assign xa[7] = x7;

    always_comb begin
        for (int c = 0; c < 8; c++) sc[c] = scale(xa[c]);
    end

    assign in_ready = !full[wr_bank];
    assign wr_en    = in_valid && in_ready;
    assign ld       = full[rd_bank] && (!out_valid || out_ready);

    // Read and write always target different banks, so the clear and set never collide.
    always_comb begin
        full_nxt = full;
        if (ld && rd_col == 3'd7)    full_nxt[rd_bank] = 1'b0;
        if (wr_en && wr_row == 3'd7) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int c = 0; c < 8; c++) mem[wr_bank][wr_row][c] <= sc[c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            wr_row    <= 3'd0;
            rd_bank   <= 1'b0;
            rd_col    <= 3'd0;
            out_valid <= 1'b0;
            out_col   <= 3'd0;
            out_last  <= 1'b0;
            yr        <= '{default: '0};
        end else begin
            full <= full_nxt;
            if (wr_en) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) wr_bank <= !wr_bank;
            end
            if (ld) begin
                for (int i = 0; i < 8; i++) yr[i] <= mem[rd_bank][i][rd_col];
                out_col   <= rd_col;
                out_last  <= (rd_col == 3'd7);
                out_valid <= 1'b1;
                rd_col    <= rd_col + 3'd1;
                if (rd_col == 3'd7) rd_bank <= !rd_bank;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign y0 = yr[0];
    assign y1 = yr[1];
    assign y2 = yr[2];
    assign y3 = yr[3];
    assign y4 = yr[4];
    assign y5 = yr[5];
    assign y6 = yr[6];
    assign y7 = yr[7];

endmodule

// File: tb/tb_dct8_transpose_buf.sv
// Directed-sequence bench with random row data; a block-level model predicts every emitted column.
module tb_dct8_transpose_buf;

    localparam int WX = 19;
    localparam int WY = 16;
    localparam int SH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic in_ready;
    logic out_valid;
    logic out_last;
    logic [2:0] out_col;
    logic signed [WX-1:0] xin [8];
    logic signed [WY-1:0] ys [8];

    int n_cmp = 0;
    int n_err = 0;
    int pend[$];
    int expq[$];
    int colcnt = 0;
    int v[8];
    int rs_exp[8];
    int vc, first, last;

    always #5 clk = ~clk;

    dct8_transpose_buf #(.WIDTH_X(WX), .WIDTH_Y(WY), .SHIFT(SH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .x0(xin[0]), .x1(xin[1]), .x2(xin[2]), .x3(xin[3]),
        .x4(xin[4]), .x5(xin[5]), .x6(xin[6]), .x7(xin[7]),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(ys[0]), .y1(ys[1]), .y2(ys[2]), .y3(ys[3]),
        .y4(ys[4]), .y5(ys[5]), .y6(ys[6]), .y7(ys[7]),
        .out_col(out_col), .out_last(out_last)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference scaling: round-half-up division by 2^SH with floor semantics, then clamp.
    function automatic int ref_scale(input int x);
        int d, a, r;
        if (SH == 0) r = x;
        else begin
            d = 2 ** SH;
            a = x + d / 2;
            r = (a >= 0) ? a / d : -((-a + d - 1) / d);
        end
        if (r > 2 ** (WY - 1) - 1) r = 2 ** (WY - 1) - 1;
        if (r < -(2 ** (WY - 1)))  r = -(2 ** (WY - 1));
        return r;
    endfunction

    function automatic int rx();
        return int'($urandom_range(524287, 0)) - 262144;
    endfunction

    // Model: collect accepted rows; a completed block is queued in column-major order.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                for (int c = 0; c < 8; c++) pend.push_back(ref_scale(int'(xin[c])));
                if (pend.size() == 64) begin
                    for (int c = 0; c < 8; c++)
                        for (int i = 0; i < 8; i++) expq.push_back(pend[i * 8 + c]);
                    pend.delete();
                end
            end
            if (out_valid && out_ready) begin
                if (expq.size() < 8) chk("unexpected_column", out_valid, 1'b0);
                else begin
                    for (int i = 0; i < 8; i++) chk("model_y", ys[i], expq.pop_front());
                    chk("model_col", out_col, colcnt);
                    chk("model_last", out_last, colcnt == 7);
                    colcnt = (colcnt + 1) % 8;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        pend.delete();
        expq.delete();
        colcnt = 0;
    endtask

    task automatic send_row(input int r[8]);
        int w;
        for (int c = 0; c < 8; c++) xin[c] = WX'(r[c]);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 300) begin
            tick();
            w++;
        end
        if (w >= 300) chk("in_ready_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_rand_row();
        int r[8];
        for (int c = 0; c < 8; c++) r[c] = rx();
        send_row(r);
    endtask

    task automatic wait_valid(input string tag);
        int w;
        w = 0;
        while (!out_valid && w < 50) begin
            tick();
            w++;
        end
        chk(tag, out_valid, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 8; c++) xin[c] = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_col", out_col, 0);
        chk("rst_out_last", out_last, 1'b0);
        for (int i = 0; i < 8; i++) chk("rst_y", ys[i], 0);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", in_ready, 1'b1);

        // Transpose with exact values: x = 4*(8r+c) scales to 8r+c.
        out_ready = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) v[c] = 4 * (8 * r + c);
            send_row(v);
        end
        chk("tp_not_early", out_valid, 1'b0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("tp_valid", out_valid, 1'b1);
            chk("tp_col", out_col, k);
            chk("tp_last", out_last, k == 7);
            for (int i = 0; i < 8; i++) chk("tp_y", ys[i], 8 * i + k);
        end
        tick();
        chk("tp_idle", out_valid, 1'b0);

        // Rounding and saturation on row 0, column by column through y0.
        v = '{6, -6, 5, -7, 262143, -262144, 0, 1};
        rs_exp = '{2, -1, 1, -2, 32767, -32768, 0, 0};
        send_row(v);
        for (int r = 1; r < 8; r++) send_rand_row();
        wait_valid("rs_wait");
        for (int k = 0; k < 8; k++) begin
            chk("rs_y0", ys[0], rs_exp[k]);
            tick();
        end
        chk("rs_idle", out_valid, 1'b0);

        // Backpressure: fill both banks, then drain block 0.
        out_ready = 1'b0;
        for (int a = 0; a < 16; a++) begin
            chk("bp_in_ready_hi", in_ready, 1'b1);
            for (int c = 0; c < 8; c++) xin[c] = WX'(rx());
            in_valid = 1'b1;
            tick();
        end
        chk("bp_full", in_ready, 1'b0);
        for (int c = 0; c < 8; c++) xin[c] = WX'(rx());
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("bp_stall_ready", in_ready, 1'b0);
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_col", out_col, 0);
            chk("bp_hold_y0", ys[0], expq[0]);
        end
        out_ready = 1'b1;
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("bp_drain_col", out_col, j);
            chk("bp_drain_ready", in_ready, j == 7);
        end
        tick();
        in_valid = 1'b0;
        for (int r = 0; r < 3; r++) send_rand_row();
        repeat (12) tick();
        chk("bp_partial_held", out_valid, 1'b0);
        for (int r = 0; r < 4; r++) send_rand_row();
        repeat (12) tick();
        chk("bp_done", out_valid, 1'b0);

        // Continuous streaming of 4 blocks.
        out_ready = 1'b1;
        vc = 0;
        first = -1;
        last = -1;
        for (int t = 0; t < 42; t++) begin
            if (t < 32) begin
                for (int c = 0; c < 8; c++) xin[c] = WX'(rx());
                in_valid = 1'b1;
                chk("cs_in_ready", in_ready, 1'b1);
            end else in_valid = 1'b0;
            tick();
            if (out_valid) begin
                vc++;
                if (first < 0) first = t;
                last = t;
            end
        end
        chk("cs_cols", vc, 32);
        chk("cs_first", first, 8);
        chk("cs_span", last - first, 31);

        // Reset after a partial block.
        for (int r = 0; r < 5; r++) send_rand_row();
        #2 rst = 1'b1;
        #1;
        chk("rr1_valid", out_valid, 1'b0);
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rr1_in_ready", in_ready, 1'b1);

        // Reset during a column drain.
        for (int r = 0; r < 8; r++) send_rand_row();
        wait_valid("rr2_wait");
        repeat (3) tick();
        chk("rr2_pre_col", out_col, 3);
        #2 rst = 1'b1;
        #1;
        chk("rr2_valid", out_valid, 1'b0);
        chk("rr2_col", out_col, 0);
        chk("rr2_last", out_last, 1'b0);
        for (int i = 0; i < 8; i++) chk("rr2_y", ys[i], 0);
        clear_model();
        @(posedge clk);
        #1 rst = 1'b0;
        for (int r = 0; r < 8; r++) send_rand_row();
        wait_valid("rr3_wait");
        chk("rr3_col0", out_col, 0);
        repeat (10) tick();
        chk("rr3_idle", out_valid, 1'b0);
        chk("model_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
